// File: rtl/vector_addition_flex_pkg.sv
// Shared single-precision float definitions: field widths, special encodings,
// the FSM state type and small field-extract helpers.
package fp_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] x);
        return x[22:0];
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Zero exponent covers both true zeros and subnormals, which are flushed.
    function automatic logic fp_is_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00);
    endfunction

    // Leading-zero count of a 27-bit aligned significand (27 when all zero).
    function automatic logic [4:0] clz27(input logic [26:0] x);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && x[i]) begin
                found = 1'b1;
            end else if (!found) begin
                n = n + 5'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/vector_addition_flex_floating_addition.sv
// Combinational single-precision adder: guard/round/sticky alignment,
// round-to-nearest-even, subnormals flushed to signed zero.
module floating_addition
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic              sa_s, sb_s;
    logic [7:0]        ea_s, eb_s;
    logic [22:0]       ma_s, mb_s;
    logic              a_big_s, s_big_s, eff_sub_s;
    logic [7:0]        e_big_s, e_diff_s;
    logic [26:0]       sig_big_s, sig_small_s, mask_s, aligned_s;
    logic [27:0]       raw_s;
    logic [4:0]        lz_s;
    logic [26:0]       norm_s;
    logic signed [9:0] e_norm_s, e_fin_s;
    logic              round_up_s;
    logic [24:0]       mant_rnd_s;
    logic [22:0]       frac_s;
    logic [31:0]       normal_sum_s;

    assign sa_s = fp_sign(a);
    assign sb_s = fp_sign(b);
    assign ea_s = fp_exp(a);
    assign eb_s = fp_exp(b);
    assign ma_s = fp_man(a);
    assign mb_s = fp_man(b);

    // Align, add/subtract, normalise and round two finite non-zero operands.
    always_comb begin
        a_big_s     = ({ea_s, ma_s} >= {eb_s, mb_s});
        s_big_s     = a_big_s ? sa_s : sb_s;
        eff_sub_s   = sa_s ^ sb_s;
        e_big_s     = a_big_s ? ea_s : eb_s;
        e_diff_s    = a_big_s ? (ea_s - eb_s) : (eb_s - ea_s);
        sig_big_s   = a_big_s ? {1'b1, ma_s, 3'b000} : {1'b1, mb_s, 3'b000};
        sig_small_s = a_big_s ? {1'b1, mb_s, 3'b000} : {1'b1, ma_s, 3'b000};
        // Shifted-out bits collapse into the sticky bit at position 0.
        if (e_diff_s >= 8'd27) begin
            mask_s    = 27'h7FF_FFFF;
            aligned_s = {26'd0, 1'b1};
        end else begin
            mask_s    = (27'd1 << e_diff_s) - 27'd1;
            aligned_s = (sig_small_s >> e_diff_s) | {26'd0, |(sig_small_s & mask_s)};
        end
        raw_s = eff_sub_s ? ({1'b0, sig_big_s} - {1'b0, aligned_s})
                          : ({1'b0, sig_big_s} + {1'b0, aligned_s});
        lz_s  = clz27(raw_s[26:0]);
        if (raw_s[27]) begin
            norm_s   = {raw_s[27:2], raw_s[1] | raw_s[0]};
            e_norm_s = $signed({2'b00, e_big_s}) + 10'sd1;
        end else begin
            norm_s   = raw_s[26:0] << lz_s;
            e_norm_s = $signed({2'b00, e_big_s}) - $signed({5'b00000, lz_s});
        end
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_rnd_s = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
        e_fin_s    = mant_rnd_s[24] ? (e_norm_s + 10'sd1) : e_norm_s;
        frac_s     = mant_rnd_s[24] ? mant_rnd_s[23:1] : mant_rnd_s[22:0];
        if (raw_s == 28'd0) begin
            normal_sum_s = 32'h0000_0000;
        end else if (e_fin_s >= 10'sd255) begin
            normal_sum_s = s_big_s ? NEG_INF : POS_INF;
        end else if (e_fin_s <= 10'sd0) begin
            normal_sum_s = {s_big_s, 31'd0};
        end else begin
            normal_sum_s = {s_big_s, e_fin_s[7:0], frac_s};
        end
    end

    // Resolve NaN/infinity/zero operands ahead of the arithmetic path.
    always_comb begin
        if (fp_is_nan(a) || fp_is_nan(b)) begin
            sum = QNAN;
        end else if (fp_is_inf(a) && fp_is_inf(b)) begin
            sum = (sa_s != sb_s) ? QNAN : a;
        end else if (fp_is_inf(a)) begin
            sum = a;
        end else if (fp_is_inf(b)) begin
            sum = b;
        end else if (fp_is_zero(a) && fp_is_zero(b)) begin
            sum = {sa_s & sb_s, 31'd0};
        end else if (fp_is_zero(a)) begin
            sum = b;
        end else if (fp_is_zero(b)) begin
            sum = a;
        end else begin
            sum = normal_sum_s;
        end
    end

endmodule

// File: rtl/vector_addition_flex.sv
// Element-wise vector adder: one shared float adder, one element per cycle,
// restarting whenever any operand or the length changes.
module vector_addition_flex
    import fp_pkg::*;
#(
    parameter int LBUF = 6
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*LBUF-1:0]   A,
    input  logic [32*LBUF-1:0]   B,
    input  logic [31:0]          l,
    output logic [32*LBUF-1:0]   result,
    output logic                 done
);

    localparam int CNT_W = $clog2(LBUF + 1);

    state_e              state_q;
    logic [CNT_W-1:0]    idx_q;
    logic [32*LBUF-1:0]  a_sh_q, b_sh_q, result_q;
    logic [31:0]         l_sh_q;
    logic                done_q;
    logic                first_q;

    logic [CNT_W-1:0]    n_s;
    logic                changed_s, last_s;
    logic [31:0]         op_a_s, op_b_s, sum_s;

    // Active length clamped to the buffer size; restart on any input change.
    assign n_s       = (l_sh_q > 32'(LBUF)) ? CNT_W'(LBUF) : l_sh_q[CNT_W-1:0];
    assign changed_s = first_q || (A != a_sh_q) || (B != b_sh_q) || (l != l_sh_q);
    assign last_s    = ((idx_q + CNT_W'(1)) == n_s);

    // Select the current element's operands from the shadow copies.
    always_comb begin
        op_a_s = 32'h0000_0000;
        op_b_s = 32'h0000_0000;
        for (int i = 0; i < LBUF; i++) begin
            if (idx_q == CNT_W'(i)) begin
                op_a_s = a_sh_q[32*i +: 32];
                op_b_s = b_sh_q[32*i +: 32];
            end else begin
                op_a_s = op_a_s;
                op_b_s = op_b_s;
            end
        end
    end

    floating_addition u_fadd (
        .a   (op_a_s),
        .b   (op_b_s),
        .sum (sum_s)
    );

    // Restart/RUN/DONE sequencing and the result register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            idx_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            l_sh_q   <= 32'd0;
            result_q <= '0;
            done_q   <= 1'b0;
            first_q  <= 1'b1;
        end else if (changed_s) begin
            a_sh_q   <= A;
            b_sh_q   <= B;
            l_sh_q   <= l;
            result_q <= '0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            state_q  <= ST_RUN;
            first_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (n_s == CNT_W'(0)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        for (int i = 0; i < LBUF; i++) begin
                            if (idx_q == CNT_W'(i)) begin
                                result_q[32*i +: 32] <= sum_s;
                            end
                        end
                        idx_q <= idx_q + CNT_W'(1);
                        if (last_s) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_vector_addition_flex.sv
// Randomised and directed bench for vector_addition_flex against a model that
// adds in double precision and rounds once to single.
module tb_vector_addition_flex;

    localparam int LBUF = 6;
    localparam int VW   = 32 * LBUF;

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] A, B;
    logic [31:0]   l;
    logic [VW-1:0] result;
    logic          done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_addition_flex #(.LBUF(LBUF)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .l      (l),
        .result (result),
        .done   (done)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single -> real, subnormals flushed to signed zero.
    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e11;
        logic [63:0] d;
        e11 = {3'b000, x[30:23]} + 11'd896;
        if (x[30:23] == 8'h00) d = {x[31], 63'd0};
        else                   d = {x[31], e11, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Real -> single with round-to-nearest-even, overflow to inf, underflow to zero.
    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d;
        logic [24:0] m;
        logic [28:0] rem;
        int          e;
        d = $realtobits(v);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {2'b01, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return 32'h7FC0_0000;
        if (is_inf(a) && is_inf(b)) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Expected result after k edges past the restart: elements below min(n,k) valid.
    function automatic logic [VW-1:0] expect_vec(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                                 input int n, input int k);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < LBUF; i++)
            if (i < n && i < k) v[32*i +: 32] = ref_add(a[32*i +: 32], b[32*i +: 32]);
        return v;
    endfunction

    function automatic logic [VW-1:0] pack6(input logic [31:0] e0, input logic [31:0] e1,
                                            input logic [31:0] e2, input logic [31:0] e3,
                                            input logic [31:0] e4, input logic [31:0] e5);
        return {e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        int          sel;
        x   = $urandom;
        sel = $urandom_range(0, 19);
        case (sel)
            0:       x[30:23] = 8'hFF;
            1:       x[30:23] = 8'h00;
            2:       x[30:23] = 8'hFE;
            default: x[30:23] = 8'(120 + $urandom_range(0, 14));
        endcase
        return x;
    endfunction

    // Inputs were changed at a negedge: k=0 is the restart edge, then k edges of work.
    task automatic observe(input string tag, input int cycles);
        int n;
        int dn;
        n  = (l > 32'(LBUF)) ? LBUF : int'(l);
        dn = (n == 0) ? 1 : n;
        for (int k = 0; k <= cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s/res k=%0d", tag, k), result, expect_vec(A, B, n, k));
            check($sformatf("%s/done k=%0d", tag, k), VW'(done), VW'((k >= dn) ? 1 : 0));
        end
    endtask

    logic [VW-1:0] va, vb, na, nb;
    logic [31:0]   nl, ea, eb;

    initial begin
        va = pack6(32'h404CCCCC, 32'h3F28F5C2, 32'hBF000000, 32'hBF000000, 32'hBF000000, 32'hBF000000);
        vb = pack6(32'h40866666, 32'h3F028F5C, 32'hC0CCCCCC, 32'h40CCCCCC, 32'hC0CCCCCC, 32'h40CCCCCC);

        rst = 1'b1;
        A   = va;
        B   = vb;
        l   = 32'd3;
        #12;
        check("reset/res", result, '0);
        check("reset/done", VW'(done), '0);
        @(negedge clk);
        rst = 1'b0;
        observe("l3", 5);
        check("l3/e0", VW'(result[31:0]), VW'(32'h40ECCCCC));
        check("l3/e2", VW'(result[95:64]), VW'(32'hC0DCCCCC));

        @(negedge clk);
        l = 32'd6;
        observe("l6", 8);
        check("l6/e3", VW'(result[127:96]), VW'(32'h40BCCCCC));
        check("l6/e4", VW'(result[159:128]), VW'(32'hC0DCCCCC));
        check("l6/e5", VW'(result[191:160]), VW'(32'h40BCCCCC));

        l = 32'd0;
        observe("l0", 2);

        l = 32'd100;
        observe("l100", 8);

        // Change one operand while done is high.
        B[31:0] = 32'h3F800000;
        observe("chgB0", 8);

        // Special values and rounding boundaries.
        A = pack6(32'h7F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h7FC12345, 32'h00400000);
        B = pack6(32'hFF800000, 32'hBF800000, 32'h7F7FFFFF, 32'h33800000, 32'h3F800000, 32'h80400000);
        l = 32'd6;
        observe("spec", 8);
        check("spec/infinf", VW'(result[31:0]), VW'(32'h7FC00000));
        check("spec/cancel", VW'(result[63:32]), VW'(32'h00000000));
        check("spec/ovf", VW'(result[95:64]), VW'(32'h7F800000));
        check("spec/tie", VW'(result[127:96]), VW'(32'h3F800000));
        check("spec/nan", VW'(result[159:128]), VW'(32'h7FC00000));
        check("spec/subn", VW'(result[191:160]), VW'(32'h00000000));

        // Asynchronous reset in the middle of a run.
        A = va;
        B = vb;
        observe("prerst", 3);
        rst = 1'b1;
        #1;
        check("midrst/res", result, '0);
        check("midrst/done", VW'(done), '0);
        @(negedge clk);
        rst = 1'b0;
        observe("postrst", 8);

        // Randomised runs, some cut short by a new input set.
        for (int it = 0; it < 60; it++) begin
            int n, full, cyc, sel;
            for (int i = 0; i < LBUF; i++) begin
                ea = rnd_fp();
                case ($urandom_range(0, 7))
                    0:       eb = ea ^ 32'h8000_0000;
                    1:       eb = (ea ^ 32'h8000_0000) + 32'd1;
                    default: eb = rnd_fp();
                endcase
                na[32*i +: 32] = ea;
                nb[32*i +: 32] = eb;
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      nl = 32'd100;
            else if (sel == 1) nl = 32'hFFFF_FFFF;
            else               nl = 32'($urandom_range(0, LBUF + 1));
            if (na == A && nb == B && nl == l) nb[0] = ~nb[0];
            A = na;
            B = nb;
            l = nl;
            n    = (nl > 32'(LBUF)) ? LBUF : int'(nl);
            full = ((n == 0) ? 1 : n) + 1;
            cyc  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, full - 1) : full;
            observe($sformatf("rnd%0d", it), cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
